// File: rtl/sys_bridge_n.sv
// System bridge between the CPU data-memory port and up to six memory-mapped peripherals.
// Decodes per-device windows plus a CTRL window and maps device interrupts onto HW[7:2].
module sys_bridge_n #(
  parameter int unsigned N_DEV    = 2,
  parameter logic [31:0] BASE     = 32'h0000_7F00,
  parameter logic [31:0] STRIDE   = 32'h10,
  parameter logic [5:0]  IRQ_EDGE = 6'b000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [31:0]           dev_addr,
  output logic [31:0]           dev_wdata,
  output logic [N_DEV-1:0]      dev_we,
  input  logic [32*N_DEV-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]      dev_irq,
  output logic [5:0]            HW
);

  localparam int unsigned    SH   = $clog2(STRIDE);
  localparam logic [31:0]    SPAN = 32'(N_DEV * STRIDE);
  localparam int unsigned    IW   = 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic [1:0] {K_NONE, K_DEV, K_CTRL} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d, dec_kind;
  logic [IW-1:0]     idx_q, idx_d, dec_idx;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [N_DEV-1:0]  dev_we_q, dev_we_d;
  logic [N_DEV-1:0]  mask_q, mask_d;
  logic [N_DEV-1:0]  clr_c;
  logic [N_DEV-1:0]  s1_q, s2_q, s3_q;
  logic [N_DEV-1:0]  pend_q, pend_d;
  logic [N_DEV-1:0]  hw_q;
  logic [31:0]       addr_w, off, coff;
  logic [31:0]       dev_rd_sel;

  // Address decode; offsets wrap for addresses below BASE, so they fall through as unmapped.
  assign addr_w = {cpu_addr[31:2], 2'b00};
  assign off    = addr_w - BASE;
  assign coff   = off - SPAN;

  always_comb begin
    dec_kind = K_NONE;
    dec_idx  = '0;
    if (off < SPAN) begin
      dec_kind = K_DEV;
      dec_idx  = IW'(off >> SH);
    end else if (coff < 32'd8) begin
      dec_kind = K_CTRL;
      dec_idx  = {2'b00, coff[2]};
    end
  end

  // Read-data slice of the latched target device.
  always_comb begin
    dev_rd_sel = '0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      if (idx_q == IW'(k)) dev_rd_sel = dev_rdata[32*k +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kind_q   <= K_NONE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      dev_we_q <= '0;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      dev_we_q <= dev_we_d;
      mask_q   <= mask_d;
    end
  end

  // Access FSM: IDLE latches the request, ACCESS performs it, RESP presents the response.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    dev_we_d = '0;
    mask_d   = mask_q;
    clr_c    = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_we || cpu_re) begin
          state_d = S_ACCESS;
          kind_d  = dec_kind;
          idx_d   = dec_idx;
          wr_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (cpu_we && dec_kind == K_DEV) begin
            for (int unsigned k = 0; k < N_DEV; k++) begin
              if (dec_idx == IW'(k)) dev_we_d[k] = 1'b1;
            end
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        ready_d = 1'b1;
        case (kind_q)
          K_DEV: begin
            if (!wr_q) rdata_d = dev_rd_sel;
          end
          K_CTRL: begin
            if (wr_q) begin
              if (idx_q[0]) mask_d = wdata_q[N_DEV-1:0];
              else          clr_c  = wdata_q[N_DEV-1:0];
            end else begin
              rdata_d = idx_q[0] ? 32'(mask_q) : 32'(pend_q);
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending update: level follows the synchroniser; edge latches until cleared, set beats clear.
  always_comb begin
    pend_d = '0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      if (IRQ_EDGE[k]) pend_d[k] = (s2_q[k] & ~s3_q[k]) | (pend_q[k] & ~clr_c[k]);
      else             pend_d[k] = s2_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      hw_q   <= '0;
    end else begin
      s1_q   <= dev_irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      hw_q   <= pend_q & mask_q;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_we    = dev_we_q;
  assign HW        = 6'(hw_q);

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n: N_DEV=2, device 0 edge-latched, device 1 level.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_ready, cpu_err;
  logic [31:0] dev_addr, dev_wdata;
  logic [1:0]  dev_we;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_irq;
  logic [5:0]  HW;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd, wda;
  logic        er;
  logic [1:0]  wea;
  logic [5:0]  hwr;
  logic        saw_rdy, saw_we;

  always #5 clk = ~clk;

  sys_bridge_n #(
    .N_DEV(2), .BASE(32'h0000_7F00), .STRIDE(32'h10), .IRQ_EDGE(6'b000001)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we),
    .dev_rdata(dev_rdata), .dev_irq(dev_irq), .HW(HW)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One bus transaction, driven at a falling edge; checks the 2-cycle ready timing.
  task automatic bus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd_o, output logic er_o, output logic [1:0] we_acc,
                     output logic [31:0] wd_acc, output logic [5:0] hw_resp);
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    we_acc = dev_we;
    wd_acc = dev_wdata;
    check_eq("rdy_in_access", 32'(cpu_ready), 32'd0);
    check_eq("dev_addr_latch", dev_addr, addr);
    @(negedge clk);
    check_eq("rdy_in_resp", 32'(cpu_ready), 32'd1);
    check_eq("we_in_resp", 32'(dev_we), 32'd0);
    rd_o = cpu_rdata; er_o = cpu_err; hw_resp = HW;
    cpu_we = 1'b0; cpu_re = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_resp", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    dev_irq = '0;
    dev_rdata = {32'hAAAA_5555, 32'h1234_5678};
    @(negedge clk); @(negedge clk);
    check_eq("rst_ready", 32'(cpu_ready), 32'd0);
    check_eq("rst_err",   32'(cpu_err),   32'd0);
    check_eq("rst_rdata", cpu_rdata,      32'd0);
    check_eq("rst_dev_we", 32'(dev_we),   32'd0);
    check_eq("rst_dev_addr", dev_addr,    32'd0);
    check_eq("rst_HW", 32'(HW),           32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Device accesses
    bus(1'b1, 1'b0, 32'h7F14, 32'hDEAD_BEEF, rd, er, wea, wda, hwr);
    check_eq("wr1_dev_we", 32'(wea), 32'd2);
    check_eq("wr1_wdata", wda, 32'hDEAD_BEEF);
    check_eq("wr1_err", 32'(er), 32'd0);
    check_eq("wr1_rdata", rd, 32'd0);
    check_eq("wdata_hold", dev_wdata, 32'hDEAD_BEEF);

    bus(1'b0, 1'b1, 32'h7F04, 32'd0, rd, er, wea, wda, hwr);
    check_eq("rd0_rdata", rd, 32'h1234_5678);
    check_eq("rd0_err", 32'(er), 32'd0);
    check_eq("rd0_no_we", 32'(wea), 32'd0);

    bus(1'b0, 1'b1, 32'h7F1F, 32'd0, rd, er, wea, wda, hwr);
    check_eq("rd1_rdata", rd, 32'hAAAA_5555);

    bus(1'b1, 1'b1, 32'h7F00, 32'h0000_0011, rd, er, wea, wda, hwr);
    check_eq("wr_re_is_write", 32'(wea), 32'd1);
    check_eq("wr_re_rdata", rd, 32'd0);

    // Unmapped
    bus(1'b0, 1'b1, 32'h7F28, 32'd0, rd, er, wea, wda, hwr);
    check_eq("unm_rd_err", 32'(er), 32'd1);
    check_eq("unm_rd_rdata", rd, 32'd0);
    check_eq("unm_rd_we", 32'(wea), 32'd0);
    bus(1'b1, 1'b0, 32'h7F28, 32'hFFFF_FFFF, rd, er, wea, wda, hwr);
    check_eq("unm_wr_err", 32'(er), 32'd1);
    check_eq("unm_wr_we", 32'(wea), 32'd0);
    bus(1'b0, 1'b1, 32'h7EFC, 32'd0, rd, er, wea, wda, hwr);
    check_eq("below_base_err", 32'(er), 32'd1);

    // CTRL reset contents
    bus(1'b0, 1'b1, 32'h7F24, 32'd0, rd, er, wea, wda, hwr);
    check_eq("mask_rst", rd, 32'd3);
    check_eq("mask_rd_err", 32'(er), 32'd0);
    bus(1'b0, 1'b1, 32'h7F20, 32'd0, rd, er, wea, wda, hwr);
    check_eq("pend_rst", rd, 32'd0);

    // Edge interrupt on device 0: one-cycle pulse
    dev_irq[0] = 1'b1;
    @(negedge clk); dev_irq[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("edge_HW_e3", 32'(HW), 32'd0);
    @(negedge clk);
    check_eq("edge_HW_e4", 32'(HW), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("edge_HW_hold", 32'(HW), 32'd1);
    bus(1'b0, 1'b1, 32'h7F20, 32'd0, rd, er, wea, wda, hwr);
    check_eq("edge_pend_rd", rd, 32'd1);
    bus(1'b1, 1'b0, 32'h7F20, 32'd1, rd, er, wea, wda, hwr);
    check_eq("w1c_HW_resp", 32'(hwr), 32'd1);
    check_eq("w1c_HW_after", 32'(HW), 32'd0);

    // Pulse whose rising edge reaches s2 during the clearing ACCESS: set wins
    dev_irq[0] = 1'b1;
    @(negedge clk); dev_irq[0] = 1'b0;
    bus(1'b1, 1'b0, 32'h7F20, 32'd1, rd, er, wea, wda, hwr);
    check_eq("set_wins_HW", 32'(HW), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("set_wins_hold", 32'(HW), 32'd1);
    bus(1'b1, 1'b0, 32'h7F20, 32'd1, rd, er, wea, wda, hwr);
    check_eq("reclear_HW", 32'(HW), 32'd0);

    // Level interrupt on device 1 with masking
    bus(1'b1, 1'b0, 32'h7F24, 32'd1, rd, er, wea, wda, hwr);
    dev_irq[1] = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("lvl_masked_HW", 32'(HW), 32'd0);
    bus(1'b0, 1'b1, 32'h7F20, 32'd0, rd, er, wea, wda, hwr);
    check_eq("lvl_pend_rd", rd, 32'd2);
    bus(1'b1, 1'b0, 32'h7F20, 32'd2, rd, er, wea, wda, hwr);
    bus(1'b0, 1'b1, 32'h7F20, 32'd0, rd, er, wea, wda, hwr);
    check_eq("lvl_w1c_no_effect", rd, 32'd2);
    bus(1'b1, 1'b0, 32'h7F24, 32'd3, rd, er, wea, wda, hwr);
    check_eq("unmask_HW_resp", 32'(hwr), 32'd0);
    check_eq("unmask_HW_after", 32'(HW), 32'd2);
    dev_irq[1] = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("lvl_drop_HW", 32'(HW), 32'd0);

    // Reset during ACCESS of a write
    bus(1'b1, 1'b0, 32'h7F24, 32'd1, rd, er, wea, wda, hwr);
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'h7F00; cpu_wdata = 32'h55;
    @(negedge clk);
    check_eq("mid_access_we", 32'(dev_we), 32'd1);
    reset = 1'b0;
    cpu_we = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(dev_we), 32'd0);
    check_eq("mid_rst_ready", 32'(cpu_ready), 32'd0);
    check_eq("mid_rst_addr", dev_addr, 32'd0);
    check_eq("mid_rst_wdata", dev_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_rdy = 1'b0; saw_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ready) saw_rdy = 1'b1;
      if (dev_we != 2'b00) saw_we = 1'b1;
    end
    check_eq("abort_no_ready", 32'(saw_rdy), 32'd0);
    check_eq("abort_no_we", 32'(saw_we), 32'd0);
    bus(1'b0, 1'b1, 32'h7F24, 32'd0, rd, er, wea, wda, hwr);
    check_eq("mask_after_rst", rd, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
